// File: rtl/shifter_pkg.sv
// Shared types and default widths for the barrel shifter and its normalizer partner.
package shifter_pkg;

   localparam int DEF_N    = 8;
   localparam int DEF_LOGN = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } norm_state_t;

endpackage

// File: rtl/seq_normalizer.sv
// Multi-cycle left normalizer: shifts one bit per clock until the MSB is set, counting shifts.
// Latency k+2 cycles for leading-zero count k (1 cycle for zero input); start ignored while busy.
module seq_normalizer
   import shifter_pkg::*;
#(
   parameter int N    = DEF_N,
   parameter int LOGN = DEF_LOGN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [N-1:0]    in,
   output logic            busy,
   output logic            done,
   output logic [N-1:0]    out,
   output logic [LOGN-1:0] sh_amt,
   output logic            zero
);

   norm_state_t     state_q, state_d;
   logic [N-1:0]    acc_q, acc_d;
   logic [LOGN-1:0] cnt_q, cnt_d;
   logic            zero_q, zero_d;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      zero_d  = zero_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               acc_d  = in;
               cnt_d  = '0;
               zero_d = (in == '0);
               state_d = (in == '0) ? ST_DONE : ST_SHIFT;
            end else if (state_q == ST_DONE) begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            // A nonzero word reaches MSB=1 within N-1 shifts, so cnt cannot wrap.
            if (acc_q[N-1]) begin
               state_d = ST_DONE;
            end else begin
               acc_d = acc_q << 1;
               cnt_d = cnt_q + LOGN'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         zero_q  <= zero_d;
      end
   end

   assign busy   = (state_q == ST_SHIFT);
   assign done   = (state_q == ST_DONE);
   assign out    = acc_q;
   assign sh_amt = cnt_q;
   assign zero   = zero_q;

endmodule

// File: tb/tb_seq_normalizer.sv
// Directed self-checking bench for seq_normalizer; cycle c is the period after edge c.
module tb_seq_normalizer;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] in_w;
   logic       busy;
   logic       done;
   logic [7:0] out_w;
   logic [2:0] sh_amt;
   logic       zero;

   int compared = 0;
   int mismatched = 0;

   seq_normalizer #(.N(8), .LOGN(3)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .in     (in_w),
      .busy   (busy),
      .done   (done),
      .out    (out_w),
      .sh_amt (sh_amt),
      .zero   (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Launch one operation and check busy/done cycle by cycle up to the done pulse and one cycle after.
   task automatic run_op(input string tag, input logic [7:0] v, input int lat,
                         input logic [7:0] out_e, input logic [2:0] sh_e, input logic zero_e);
      in_w  = v;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < lat; c++) begin
         check({tag, "_busy"}, busy, 1'b1);
         check({tag, "_nodone"}, done, 1'b0);
         tick();
      end
      check({tag, "_done"}, done, 1'b1);
      check({tag, "_busy_at_done"}, busy, 1'b0);
      check({tag, "_out"}, out_w, out_e);
      check({tag, "_sh_amt"}, sh_amt, sh_e);
      check({tag, "_zero"}, zero, zero_e);
      tick();
      check({tag, "_done_drop"}, done, 1'b0);
      check({tag, "_out_hold"}, out_w, out_e);
      check({tag, "_sh_hold"}, sh_amt, sh_e);
   endtask

   initial begin
      int pulses;
      rst_n = 1'b0;
      start = 1'b0;
      in_w  = 8'h00;
      tick();
      tick();
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_out", out_w, 8'h00);
      check("rst_sh", sh_amt, 3'd0);
      check("rst_zero", zero, 1'b0);
      rst_n = 1'b1;
      tick();

      run_op("norm", 8'b1001_1101, 2, 8'b1001_1101, 3'd0, 1'b0);
      run_op("max", 8'b0000_0001, 9, 8'b1000_0000, 3'd7, 1'b0);
      run_op("mid", 8'b0010_1101, 4, 8'b1011_0100, 3'd2, 1'b0);
      check("mid_inverse", out_w >> sh_amt, 8'b0010_1101);
      run_op("zero", 8'h00, 1, 8'h00, 3'd0, 1'b1);

      // Ignored start during SHIFT, then back-to-back start in the DONE cycle.
      in_w  = 8'b0001_0000;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      in_w  = 8'hFF;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("ign_busy3", busy, 1'b1);
      tick();
      check("ign_busy4", busy, 1'b1);
      tick();
      check("ign_done5", done, 1'b1);
      check("ign_out", out_w, 8'b1000_0000);
      check("ign_sh", sh_amt, 3'd3);
      check("ign_zero", zero, 1'b0);
      in_w  = 8'b0100_0000;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("b2b_busy1", busy, 1'b1);
      check("b2b_nodone1", done, 1'b0);
      tick();
      check("b2b_busy2", busy, 1'b1);
      tick();
      check("b2b_done3", done, 1'b1);
      check("b2b_out", out_w, 8'b1000_0000);
      check("b2b_sh", sh_amt, 3'd1);

      // Reset at the cycle-3 edge aborts the operation.
      tick();
      in_w  = 8'b0000_0010;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_out", out_w, 8'h00);
      check("abort_sh", sh_amt, 3'd0);
      rst_n = 1'b1;
      pulses = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (done) pulses++;
      end
      check("abort_no_done", pulses, 0);

      // Reset wins over start at the same edge.
      in_w  = 8'h01;
      start = 1'b1;
      rst_n = 1'b0;
      tick();
      start = 1'b0;
      rst_n = 1'b1;
      check("rst_prio_busy", busy, 1'b0);
      check("rst_prio_out", out_w, 8'h00);
      tick();
      check("rst_prio_idle", busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/seq_normalizer.md
# seq_normalizer

Multi-cycle left normalizer; the inverse of the team's combinational barrel shifter. Given an N-bit word, it shifts left one bit per clock until the MSB is 1. It reports the normalized word and the shift amount, so `sh_amt` recovers the `sh_sel` that would re-create the input's leading-zero structure. It sits beside the barrel shifter in the datapath and serves as its self-check partner in the shifter test environment.

## Interface
- `N`, 8: data width.
- `LOGN`, 3: shift-amount width; must satisfy 2^LOGN ≥ N.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request; sampled only when the FSM is in IDLE or DONE.
- `in`  in  N  word to normalize; sampled with `start`.
- `busy`  out  1  high while in SHIFT.
- `done`  out  1  one-cycle pulse; results valid.
- `out`  out  N  normalized word.
- `sh_amt`  out  LOGN  number of left shifts applied (leading-zero count).
- `zero`  out  1  the input was all zeros.

Reset and clock are fixed: one clock `clk`; reset `rst_n` is synchronous and active-low.

## Operation
- States are IDLE, SHIFT and DONE.
- Working registers:
  - `acc[N-1:0]`, driven onto `out`.
  - `cnt[LOGN-1:0]`, driven onto `sh_amt`.
- Reset (`rst_n`=0 at an edge):
  - state goes to IDLE.
  - `acc`, `cnt`, `zero`, `busy` and `done` all become 0.
- IDLE or DONE with `start`=1:
  - `acc`←`in`, `cnt`←0, `zero`←0.
  - If `in`==0: go to DONE and set `zero`←1.
  - Otherwise: go to SHIFT.
- IDLE with `start`=0: stay in IDLE.
- DONE with `start`=0: go to IDLE.
- SHIFT:
  - If `acc[N-1]`=1: go to DONE.
  - Otherwise: `acc`←`acc`<<1 (zero-fill) and `cnt`←`cnt`+1.
  - For a nonzero input, `cnt` never exceeds N-1, so it cannot wrap.
- `start` during SHIFT is ignored. There is no queueing; the `in` value presented then is discarded.
- `out`, `sh_amt` and `zero` hold their last values from DONE through IDLE until the next accepted `start` reloads them.
- `busy` = (state==SHIFT). `done` = (state==DONE).
- Invariant for a nonzero input X: `out` == X << `sh_amt`, and `out[N-1]`==1.

## Timing
- Let edge 0 be the edge that samples `start`=1. Let k be the leading-zero count of a nonzero input.
- Nonzero input:
  - SHIFT occupies cycles 1 through k+1.
  - `done` is high in cycle k+2, so latency is k+2 cycles. Range: 2 (MSB already set) to N+1.
- Zero input: `done` is high in cycle 1.
- Back-to-back: `start` in the DONE cycle is accepted, so the next operation begins with no idle gap.
- Reset mid-SHIFT:
  - aborts the operation; no `done` is produced.
  - outputs are 0 from the next cycle.
- Reset has priority over `start` at the same edge.

## Structure
- Shared package `shifter_pkg` contains:
  - the FSM state typedef (IDLE, SHIFT, DONE);
  - the default localparams N=8 and LOGN=3, shared with the barrel shifter and its benches.
- There is no sub-module. The design is a single FSM plus a datapath of one shift register and one counter.

## Test plan
- **Already normalized.** `in`=8'b10011101, pulse `start` → `done` in cycle 2, `out`=8'b10011101, `sh_amt`=0, `zero`=0.
- **Maximum shift.** `in`=8'b00000001 → `busy` high for cycles 1–8, `done` in cycle 9, `out`=8'b10000000, `sh_amt`=7.
- **Mid-range value.** `in`=8'b00101101 → `done` in cycle 4, `out`=8'b10110100, `sh_amt`=2. Cross-check: feeding `out` and `sh_amt` back to the barrel shifter's right/inverse path reproduces the original word.
- **Zero input.** `in`=8'h00 → `done` in cycle 1, `zero`=1, `out`=0, `sh_amt`=0.
- **Ignored start, then back-to-back.**
  - Start `in`=8'b00010000; pulse `start` again with `in`=8'hFF in cycle 2 → the second request is ignored; `done` in cycle 5 with `out`=8'b10000000, `sh_amt`=3.
  - `start` with `in`=8'b01000000 in that same DONE cycle → the new operation is accepted; `done` 3 cycles later with `sh_amt`=1.
- **Reset mid-operation.** `in`=8'b00000010 with `rst_n`=0 at the cycle-3 edge → state IDLE; `busy`, `done`, `out` and `sh_amt` are all 0; no `done` pulse appears afterward.
